// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: ARM condition codes, NZCV bit
// positions and flag-write masks.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_CV   = 2'b01;
  localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (cond, nzcv) -> pass.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv_i[FLAG_N];
    z = nzcv_i[FLAG_Z];
    c = nzcv_i[FLAG_C];
    v = nzcv_i[FLAG_V];
    // AL and the reserved 1111 encoding both execute unconditionally.
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = ~(n ^ v);
      COND_LT: pass_o = n ^ v;
      COND_GT: pass_o = ~z & ~(n ^ v);
      COND_LE: pass_o = z | (n ^ v);
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register, condition gating of decoder strobes and
// saturating executed/skipped debug counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_write_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             pc_src_i,
  output logic             cond_ex_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             pc_src_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] skip_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic             pass;

  // Evaluated against the stored flags, never the in-flight ALU result.
  cond_check u_cond_check (
    .cond_i (cond_i),
    .nzcv_i (flags_q),
    .pass_o (pass)
  );

  always_comb begin
    cond_ex_o   = valid_i & pass;
    reg_write_o = reg_write_i & cond_ex_o;
    mem_write_o = mem_write_i & cond_ex_o;
    pc_src_o    = pc_src_i & cond_ex_o;
  end

  always_comb begin
    flags_d    = flags_q;
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (valid_i) begin
      if (cond_ex_o) begin
        if (flag_write_i[1]) begin
          flags_d[FLAG_N] = alu_flags_i[FLAG_N];
          flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
        end
        if (flag_write_i[0]) begin
          flags_d[FLAG_C] = alu_flags_i[FLAG_C];
          flags_d[FLAG_V] = alu_flags_i[FLAG_V];
        end
        if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= RESET_FLAGS;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign flags_o    = flags_q;
  assign exec_cnt_o = exec_cnt_q;
  assign skip_cnt_o = skip_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: two instances (16-bit and 2-bit counters, different
// reset flags) checked every cycle against a behavioural model.
module tb_cond_unit;
  import cond_pkg::*;

  localparam logic [3:0] RF0 = 4'b0000;
  localparam logic [3:0] RF1 = 4'b0110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic [3:0] cond_i = '0;
  logic [3:0] alu_flags_i = '0;
  logic [1:0] flag_write_i = '0;
  logic       reg_write_i = 1'b0, mem_write_i = 1'b0, pc_src_i = 1'b0;

  logic        ce0, rw0, mw0, ps0, ce1, rw1, mw1, ps1;
  logic [3:0]  fl0, fl1;
  logic [15:0] ex0, sk0;
  logic [1:0]  ex1, sk1;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(16), .RESET_FLAGS(RF0)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .cond_i(cond_i),
    .alu_flags_i(alu_flags_i), .flag_write_i(flag_write_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
    .cond_ex_o(ce0), .reg_write_o(rw0), .mem_write_o(mw0), .pc_src_o(ps0),
    .flags_o(fl0), .exec_cnt_o(ex0), .skip_cnt_o(sk0));

  cond_unit #(.CNT_W(2), .RESET_FLAGS(RF1)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .cond_i(cond_i),
    .alu_flags_i(alu_flags_i), .flag_write_i(flag_write_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
    .cond_ex_o(ce1), .reg_write_o(rw1), .mem_write_o(mw1), .pc_src_o(ps1),
    .flags_o(fl1), .exec_cnt_o(ex1), .skip_cnt_o(sk1));

  // Reference condition: pairs of codes share a base test, odd codes invert it.
  function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  logic [3:0] m_flags [2];
  int         m_exec [2];
  int         m_skip [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_flags[i] <= (i == 0) ? RF0 : RF1;
        m_exec[i]  <= 0;
        m_skip[i]  <= 0;
      end else if (valid_i) begin
        if (m_pass(cond_i, m_flags[i])) begin
          m_flags[i] <= {flag_write_i[1] ? alu_flags_i[3:2] : m_flags[i][3:2],
                         flag_write_i[0] ? alu_flags_i[1:0] : m_flags[i][1:0]};
          m_exec[i] <= m_exec[i] + 1;
        end else begin
          m_skip[i] <= m_skip[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_dut(input int i, input logic ce, input logic rw, input logic mw,
                         input logic ps, input logic [3:0] fl, input int ex, input int sk,
                         input int w);
    bit e;
    e = valid_i && m_pass(cond_i, m_flags[i]);
    chk($sformatf("u%0d cond_ex", i), {31'd0, ce}, {31'd0, e});
    chk($sformatf("u%0d reg_write", i), {31'd0, rw}, {31'd0, reg_write_i && e});
    chk($sformatf("u%0d mem_write", i), {31'd0, mw}, {31'd0, mem_write_i && e});
    chk($sformatf("u%0d pc_src", i), {31'd0, ps}, {31'd0, pc_src_i && e});
    chk($sformatf("u%0d flags", i), {28'd0, fl}, {28'd0, m_flags[i]});
    chk($sformatf("u%0d exec_cnt", i), ex, sat(m_exec[i], w));
    chk($sformatf("u%0d skip_cnt", i), sk, sat(m_skip[i], w));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut(0, ce0, rw0, mw0, ps0, fl0, int'(ex0), int'(sk0), 16);
      cmp_dut(1, ce1, rw1, mw1, ps1, fl1, int'(ex1), int'(sk1), 2);
    end
  end

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic rw, input logic mw, input logic ps);
    valid_i = v; cond_i = c; alu_flags_i = a; flag_write_i = fw;
    reg_write_i = rw; mem_write_i = mw; pc_src_i = ps;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lit_n1v1, lit_n1v0;

  initial begin
    // {LE,GT,LT,GE} for flags N=1,V=1 and N=1,V=0 (Z=0, C=0)
    lit_n1v1 = 4'b0101;
    lit_n1v0 = 4'b1010;

    repeat (2) @(posedge clk);
    #1;
    chk("reset flags", {28'd0, fl0}, 32'h0);
    chk("reset exec", {16'd0, ex0}, 32'd0);
    chk("reset skip", {16'd0, sk0}, 32'd0);
    chk("reset cond_ex", {31'd0, ce0}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    drive(1, COND_EQ, 4'b0000, FW_NONE, 1, 0, 0);
    chk("EQ after reset cond_ex", {31'd0, ce0}, 32'd0);
    chk("EQ after reset reg_write", {31'd0, rw0}, 32'd0);
    tick();
    chk("skip after EQ", {16'd0, sk0}, 32'd1);

    drive(1, COND_AL, 4'b0100, FW_ALL, 0, 0, 1);
    chk("AL pc_src", {31'd0, ps0}, 32'd1);
    tick();
    chk("flags after AL", {28'd0, fl0}, 32'h4);
    drive(1, COND_EQ, 4'b0000, FW_NONE, 0, 1, 0);
    chk("EQ sees new Z mem_write", {31'd0, mw0}, 32'd1);
    tick();
    chk("exec after two", {16'd0, ex0}, 32'd2);

    drive(1, COND_NE, 4'b1001, FW_ALL, 1, 1, 1);
    chk("NE fails cond_ex", {31'd0, ce0}, 32'd0);
    tick();
    chk("failed cond keeps flags", {28'd0, fl0}, 32'h4);

    drive(1, COND_AL, 4'b0000, FW_ALL, 0, 0, 0);
    tick();
    drive(1, COND_AL, 4'b1111, FW_NZ, 0, 0, 0);
    tick();
    chk("NZ half write", {28'd0, fl0}, 32'hC);
    drive(1, COND_AL, 4'b0011, FW_CV, 0, 0, 0);
    tick();
    chk("CV half write", {28'd0, fl0}, 32'hF);
    drive(1, COND_AL, 4'b0000, FW_NONE, 0, 0, 0);
    tick();
    chk("FW_NONE keeps flags", {28'd0, fl0}, 32'hF);
    drive(0, COND_AL, 4'b0000, FW_ALL, 1, 1, 1);
    chk("invalid suppresses reg_write", {31'd0, rw0}, 32'd0);
    tick();
    chk("invalid no commit", {28'd0, fl0}, 32'hF);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(1, COND_AL, 4'(f), FW_ALL, 0, 0, 0);
        tick();
        drive(1, 4'(c), ~4'(f), FW_ALL, 1, 1, 1);
        if (f == 9 && c >= 10 && c <= 13)
          chk("N1V1 signed cond", {31'd0, ce0}, {31'd0, lit_n1v1[c-10]});
        if (f == 8 && c >= 10 && c <= 13)
          chk("N1V0 signed cond", {31'd0, ce0}, {31'd0, lit_n1v0[c-10]});
        if (c == 15)
          chk("1111 always", {31'd0, ce0}, 32'd1);
        tick();
      end
    end

    // Reset pulled while a committing instruction is held on the inputs.
    drive(1, COND_AL, 4'b1111, FW_ALL, 1, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset flags u0", {28'd0, fl0}, 32'h0);
    chk("midreset exec u0", {16'd0, ex0}, 32'd0);
    chk("midreset skip u0", {16'd0, sk0}, 32'd0);
    chk("midreset flags u1", {28'd0, fl1}, {28'd0, RF1});
    chk("midreset exec u1", {30'd0, ex1}, 32'd0);
    drive(0, COND_AL, 4'b0000, FW_NONE, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("commit discarded", {28'd0, fl0}, 32'h0);

    for (int k = 0; k < 5; k++) begin
      drive(1, COND_AL, 4'b0000, FW_NONE, 1, 0, 0);
      tick();
    end
    chk("2-bit exec saturates", {30'd0, ex1}, 32'd3);
    chk("16-bit exec counts", {16'd0, ex0}, 32'd5);
    drive(0, COND_AL, 4'b0000, FW_NONE, 0, 0, 0);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
